// File: rtl/percept_cmd_decoder.sv
// Serial command decoder for a perceptron node: start bit, address, opcode, optional payload.
// Define PERCEPT_CMD_PARITY_EN to add an even-parity bit after the opcode (covers address and opcode).
module percept_cmd_decoder #(
    parameter int ADDR_W      = 9,
    parameter int OP_W        = 3,
    parameter int DATA_W      = 8,
    parameter int EXEC_CYCLES = 3
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              rx,
    output logic [OP_W-1:0]   opcode,
    output logic              op_valid,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              frame_err
);

    localparam int MAX_AO  = (ADDR_W > OP_W) ? ADDR_W : OP_W;
    localparam int MAX_DE  = (DATA_W > EXEC_CYCLES) ? DATA_W : EXEC_CYCLES;
    localparam int CNT_MAX = (MAX_AO > MAX_DE) ? MAX_AO : MAX_DE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef PERCEPT_CMD_PARITY_EN
    localparam int OSR_W   = OP_W;
`else
    localparam int OSR_W   = OP_W - 1;
`endif

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] OP_LAST   = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);

    localparam logic [OP_W-1:0] OP_LOAD     = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LOAD_RES = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NO_OP    = OP_W'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_OPC,
        S_PAR,
        S_DATA,
        S_SKIP,
        S_EXEC
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [OSR_W-1:0]  r_opc;
    logic [DATA_W-2:0] r_dsh;
    logic [OP_W-1:0]   r_opcode;
    logic              r_op_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_data_valid;
    logic              r_frame_err;

    logic [OP_W-1:0]   w_opc_shift;
    logic [OP_W-1:0]   w_opc_full;
    logic [DATA_W-1:0] w_dsh_shift;
    logic              w_eval_now;
    logic              w_par_ok;
    logic              w_match;
    logic              w_payload;
    logic              w_noop;

    assign w_dsh_shift = {r_dsh, rx};

    // Without parity the frame is judged on the last opcode edge, so the final bit comes straight from rx.
`ifdef PERCEPT_CMD_PARITY_EN
    assign w_opc_shift = {r_opc[OP_W-2:0], rx};
    assign w_opc_full  = r_opc;
    assign w_eval_now  = (r_state == S_PAR);
    assign w_par_ok    = ~(^{r_addr, r_opc, rx});
`else
    assign w_opc_shift = {r_opc, rx};
    assign w_opc_full  = w_opc_shift;
    assign w_eval_now  = (r_state == S_OPC) && (r_cnt == OP_LAST);
    assign w_par_ok    = 1'b1;
`endif

    assign w_match   = (r_addr == address) || (&r_addr);
    assign w_payload = (w_opc_full == OP_LOAD) || (w_opc_full == OP_LOAD_RES);
    assign w_noop    = (w_opc_full == OP_NO_OP);

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_opc        <= '0;
            r_dsh        <= '0;
            r_opcode     <= OP_NO_OP;
            r_op_valid   <= 1'b0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_op_valid   <= 1'b0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!rx) begin
                        r_state <= S_ADDR;
                        r_cnt   <= '0;
                    end
                end
                S_ADDR: begin
                    r_addr <= {r_addr[ADDR_W-2:0], rx};
                    if (r_cnt == ADDR_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_OPC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OPC: begin
                    r_opc <= w_opc_shift[OSR_W-1:0];
                    // The frame-evaluation block below overrides this when there is no parity bit.
                    if (r_cnt == OP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_PAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    r_cnt <= '0;
                end
                S_DATA: begin
                    r_dsh <= w_dsh_shift[DATA_W-2:0];
                    if (r_cnt == DATA_LAST) begin
                        r_data       <= w_dsh_shift;
                        r_data_valid <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SKIP: begin
                    if (r_cnt == DATA_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == EXEC_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase

            if (w_eval_now) begin
                r_cnt <= '0;
                if (w_match && w_par_ok) begin
                    r_opcode   <= w_opc_full;
                    r_op_valid <= 1'b1;
                    if (w_payload)
                        r_state <= S_DATA;
                    else if (w_noop)
                        r_state <= S_IDLE;
                    else
                        r_state <= S_EXEC;
                end else begin
                    r_frame_err <= ~w_par_ok;
                    // Other nodes' payload is consumed so its zeros never look like a start bit.
                    r_state     <= w_payload ? S_SKIP : S_IDLE;
                end
            end
        end
    end

    assign opcode     = r_opcode;
    assign op_valid   = r_op_valid;
    assign data       = r_data;
    assign data_valid = r_data_valid;
    assign busy       = (r_state != S_IDLE);
    assign frame_err  = r_frame_err;

endmodule

// File: doc/percept_cmd_decoder.md
# percept_cmd_decoder

Parametrised serial command decoder for a perceptron node. It supersedes the fixed 9-bit/3-bit node controller. It sits between the shared one-bit command line `rx` and the node datapath, and adds:
- configurable widths,
- a broadcast address,
- an in-frame data payload for load opcodes,
- frame skipping for other nodes' traffic, so the decoder never resynchronises mid-frame,
- optional parity checking.

## Interface
- `ADDR_W`, 9, node/frame address width (≥2)
- `OP_W`, 3, opcode width (≥3); codes are zero-extended to `OP_W`
- `DATA_W`, 8, payload width carried by LOAD/LOAD_RES
- `EXEC_CYCLES`, 3, cycles spent in EXECUTE after a non-NO_OP command (≥1)
- `clk`  in  1  clock; `rx` sampled on every rising edge (one bit per cycle)
- `Rst`  in  1  asynchronous, active-high reset
- `address`  in  `ADDR_W`  this node's address, static during operation
- `rx`  in  1  serial command line, idles high
- `opcode`  out  `OP_W`  last accepted opcode, held until the next accept
- `op_valid`  out  1  one-cycle pulse when `opcode` updates
- `data`  out  `DATA_W`  last accepted payload, held
- `data_valid`  out  1  one-cycle pulse when `data` updates
- `busy`  out  1  high in every state except IDLE
- `frame_err`  out  1  one-cycle pulse on parity failure (0 when parity is compiled out)

## Operation
- Opcodes: OUT_DATA1=0, OUT_DATA2=1, OUT_RES=2, LOAD=3, LOAD_RES=4, MUL=5, MUL_ADD=6, NO_OP=7. Payload opcodes: LOAD, LOAD_RES.
- Frame format: start bit 0, then `ADDR_W` address bits MSB first, then `OP_W` opcode bits MSB first, then [parity bit], then [`DATA_W` payload bits MSB first, payload opcodes only].
- States and transitions:
  - IDLE: on `rx`=0, go to ADDR.
  - ADDR: after `ADDR_W` samples, go to OPC.
  - OPC: after `OP_W` samples, go to PAR if parity is compiled in, otherwise evaluate.
  - PAR: after one sample, evaluate.
  - Evaluate: the frame matches if the address equals `address` or is all-ones (broadcast).
- Matched frame, parity ok:
  - Register `opcode` and pulse `op_valid`.
  - Payload opcode: go to DATA.
  - NO_OP: go to IDLE.
  - Other opcodes: go to EXEC.
- Unmatched frame, or parity error:
  - `opcode`, `data` and `op_valid` are unchanged.
  - Payload opcode: go to SKIP for `DATA_W` cycles, then IDLE.
  - Otherwise go to IDLE.
- DATA: after `DATA_W` samples, register `data`, pulse `data_valid`, go to EXEC.
- EXEC: count `EXEC_CYCLES`, then go to IDLE.
- Start bits are detected only in IDLE; `rx` is ignored in every other state.
- Counters are sized to max(`ADDR_W`, `OP_W`, `DATA_W`, `EXEC_CYCLES`) and never wrap.
- Out-of-range opcode values (≥8 when `OP_W`>3) are accepted as non-payload opcodes and go to EXEC.

## Timing
- Reset values: `opcode`=NO_OP, `data`=0, `op_valid`=0, `data_valid`=0, `busy`=0, `frame_err`=0, state IDLE, counters 0.
- Asserting `Rst` mid-frame aborts immediately. After release, the decoder waits in IDLE for a fresh start bit.
- Start bit sampled at edge E0. Then:
  - Address bits are sampled at edges E1..E`ADDR_W`.
  - Opcode bits are sampled at edges E`ADDR_W`+1..E`ADDR_W`+`OP_W`.
- `op_valid` is high in the cycle after the last opcode bit edge, or after the parity edge when parity is compiled in.
- `data_valid` is high in the cycle after the last payload edge.
- EXEC lasts exactly `EXEC_CYCLES` cycles. The first IDLE cycle can sample a new start bit, so back-to-back frames have zero gap.
- `busy` rises the cycle after the start edge and falls when the state returns to IDLE.
- `op_valid` and `data_valid` never coincide.

## Configuration
- `PERCEPT_CMD_PARITY_EN`
  - Defined: an even-parity bit follows the opcode; parity covers the address and opcode bits. On mismatch, `frame_err` pulses for one cycle (same cycle `op_valid` would have pulsed), nothing is accepted, and any payload is skipped.
  - Undefined: no PAR state, and `frame_err` is tied to 0.

## Test plan
- Defaults, `address`=0x0A5; send start, 0x0A5, MUL(5) -> `op_valid` pulse at edge 13 with `opcode`=5; `busy` high for 12+3 cycles; then IDLE.
- Send 0x0A5, LOAD(3), payload 0x3C -> `op_valid` with `opcode`=3, then `data_valid` 8 cycles later with `data`=0x3C.
- Send address 0x0A4, LOAD, payload 0x00 -> no pulses, `opcode` still NO_OP; the payload zeros do not start a new frame; a following frame to 0x0A5 with OUT_RES(2) is accepted.
- Send broadcast 0x1FF with MUL_ADD(6) -> accepted, `opcode`=6; NO_OP frame -> `op_valid` pulse, no EXEC, `busy` drops the next cycle.
- Assert `Rst` during the address bits, release, send a valid frame -> all outputs at reset values, then normal accept.
- With `PERCEPT_CMD_PARITY_EN` defined, send a frame with a flipped parity bit -> `frame_err` pulse, no `op_valid`, `opcode` unchanged.
